// File: rtl/echo_pkg.sv
// Shared definitions for the echo engine: converter bias defaults,
// FSM state encoding and the saturation helper.
package echo_pkg;

    localparam logic [9:0] ADC_OFFSET_DEF = 10'h181;
    localparam logic [9:0] DAC_OFFSET_DEF = 10'h200;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        RD,
        WB
    } echo_state_t;

    // Clamp a widened sum into [lo, hi].
    function automatic int sat_clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Delay-line storage: one write port, one synchronous read port
// with a single cycle of read latency.
module echo_delay_ram #(
    parameter int unsigned W  = 10,
    parameter int unsigned AW = 4
) (
    input  logic          sysclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1 << AW)-1];

    // Registered write and registered read.
    always_ff @(posedge sysclk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/echo_engine.sv
// Tick-strobed single-tap echo: FIR or IIR, runtime delay and
// attenuation, saturating sum, converter bias strip/restore.
module echo_engine
    import echo_pkg::*;
#(
    parameter int unsigned  W          = 10,
    parameter int unsigned  AW         = 4,
    parameter logic [W-1:0] ADC_OFFSET = W'(ADC_OFFSET_DEF),
    parameter logic [W-1:0] DAC_OFFSET = W'(DAC_OFFSET_DEF)
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic [W-1:0]  data_in,
    input  logic [AW-1:0] delay_len,
    input  logic [2:0]    gain_shift,
    input  logic          fb_mode,
    output logic [W-1:0]  data_out,
    output logic          out_valid,
    output logic          ready,
    output logic          overrun
);

    localparam int YMAX = (1 <<< (W - 1)) - 1;
    localparam int YMIN = -(1 <<< (W - 1));

    echo_state_t state, state_next;

    logic [AW-1:0]       clr_cnt;
    logic [AW-1:0]       wr_ptr;
    logic signed [W-1:0] x_reg;
    logic signed [W-1:0] echo_reg;
    logic [AW-1:0]       dl_reg;
    logic [2:0]          gs_reg;
    logic                fb_reg;

    logic                ram_we;
    logic [AW-1:0]       ram_waddr;
    logic [W-1:0]        ram_wdata;
    logic                ram_re;
    logic [AW-1:0]       ram_raddr;
    logic [W-1:0]        ram_rdata;
    logic signed [W-1:0] rd_s;
    logic signed [W-1:0] y;

    // FSM state register.
    always_ff @(posedge sysclk) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_cnt == '1) state_next = IDLE;
            IDLE:    if (tick) state_next = RD;
            RD:      state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    // Saturated output sample and RAM port steering; writes are gated by
    // reset so an aborted sample never reaches the buffer.
    always_comb begin
        y         = W'(sat_clamp(int'(x_reg) + int'(echo_reg), YMIN, YMAX));
        rd_s      = signed'(ram_rdata);
        ram_we    = rst_n && (state == CLEAR || state == WB);
        ram_waddr = (state == CLEAR) ? clr_cnt : wr_ptr;
        ram_wdata = (state == CLEAR) ? '0 : (fb_reg ? W'(y) : W'(x_reg));
        ram_re    = (state == IDLE) && tick;
        ram_raddr = wr_ptr - delay_len;
    end

    assign ready = (state != CLEAR);

    // Clear counter, write pointer, sample capture, echo and output registers.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            clr_cnt   <= '0;
            wr_ptr    <= '0;
            x_reg     <= '0;
            echo_reg  <= '0;
            dl_reg    <= '0;
            gs_reg    <= '0;
            fb_reg    <= 1'b0;
            data_out  <= DAC_OFFSET;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                CLEAR: clr_cnt <= clr_cnt + 1'b1;
                IDLE: begin
                    if (tick) begin
                        x_reg  <= signed'(data_in - ADC_OFFSET);
                        dl_reg <= delay_len;
                        gs_reg <= gain_shift;
                        fb_reg <= fb_mode;
                    end
                end
                RD: echo_reg <= (dl_reg == '0) ? '0 : (rd_s >>> gs_reg);
                WB: begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    data_out  <= W'(y) + DAC_OFFSET;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
            if ((state == RD || state == WB) && tick) overrun <= 1'b1;
        end
    end

    echo_delay_ram #(
        .W  (W),
        .AW (AW)
    ) u_ram (
        .sysclk (sysclk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .re     (ram_re),
        .raddr  (ram_raddr),
        .rdata  (ram_rdata)
    );

endmodule

// File: tb/tb_echo_engine.sv
// Scoreboard bench for echo_engine: stimulus pushes expected DAC words,
// a monitor pops and compares on every out_valid.
module tb_echo_engine;

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [9:0] data_in = 10'h181;
    logic [3:0] delay_len = '0;
    logic [2:0] gain_shift = '0;
    logic       fb_mode = 1'b0;
    logic [9:0] data_out;
    logic       out_valid;
    logic       ready;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    echo_engine #(
        .W  (10),
        .AW (4)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .tick       (tick),
        .data_in    (data_in),
        .delay_len  (delay_len),
        .gain_shift (gain_shift),
        .fb_mode    (fb_mode),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .ready      (ready),
        .overrun    (overrun)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge sysclk) begin
        if (rst_n && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got=%h want=none at %0t", data_out, $time);
            end else begin
                check("data_out", {6'b0, data_out}, {6'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d want=0 outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        drain();
        @(negedge sysclk);
        rst_n = 1'b0;
        tick  = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (17) @(negedge sysclk);
    endtask

    task automatic do_tick(input logic [9:0] din, input logic [3:0] dl, input logic [2:0] gs,
                           input logic fb, input logic [9:0] exp);
        @(negedge sysclk);
        data_in    = din;
        delay_len  = dl;
        gain_shift = gs;
        fb_mode    = fb;
        tick       = 1'b1;
        exp_q.push_back(exp);
        @(negedge sysclk);
        tick = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    initial begin
        // Reset state and clear sweep; ticks during CLEAR must be ignored.
        rst_n = 1'b0;
        repeat (2) @(negedge sysclk);
        check("rst_data_out", {6'b0, data_out}, 16'h200);
        check("rst_ready", {15'b0, ready}, 16'h0);
        check("rst_out_valid", {15'b0, out_valid}, 16'h0);
        check("rst_overrun", {15'b0, overrun}, 16'h0);
        rst_n   = 1'b1;
        data_in = 10'h281;
        tick    = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge sysclk);
            if (i == 15) tick = 1'b0;
            check($sformatf("ready_c%0d", i), {15'b0, ready}, (i == 16) ? 16'h1 : 16'h0);
        end
        repeat (6) @(negedge sysclk);
        check("clear_overrun", {15'b0, overrun}, 16'h0);
        check("clear_data_out", {6'b0, data_out}, 16'h200);

        // FIR impulse, delay 4, half gain.
        do_reset();
        do_tick(10'h281, 4'd4, 3'd1, 1'b0, 10'h300);
        for (int k = 1; k <= 8; k++)
            do_tick(10'h181, 4'd4, 3'd1, 1'b0, (k == 4) ? 10'h280 : 10'h200);

        // IIR impulse: decaying repeats every 4 ticks.
        do_reset();
        do_tick(10'h281, 4'd4, 3'd1, 1'b1, 10'h300);
        for (int k = 1; k <= 16; k++) begin
            logic [9:0] e;
            e = 10'h200;
            if (k % 4 == 0) e = 10'h200 + (10'h100 >> (k / 4));
            do_tick(10'h181, 4'd4, 3'd1, 1'b1, e);
        end

        // Saturation at both rails.
        do_reset();
        do_tick(10'h380, 4'd1, 3'd0, 1'b0, 10'h3FF);
        do_tick(10'h380, 4'd1, 3'd0, 1'b0, 10'h3FF);
        do_tick(10'h381, 4'd1, 3'd0, 1'b0, 10'h1FF);
        do_tick(10'h381, 4'd1, 3'd0, 1'b0, 10'h000);

        // Overrun with pass-through: three back-to-back ticks, one output.
        do_reset();
        @(negedge sysclk);
        data_in   = 10'h1C1;
        delay_len = 4'd0;
        tick      = 1'b1;
        exp_q.push_back(10'h240);
        repeat (3) @(negedge sysclk);
        tick = 1'b0;
        repeat (4) @(negedge sysclk);
        check("overrun_set", {15'b0, overrun}, 16'h1);
        do_tick(10'h1C1, 4'd0, 3'd0, 1'b0, 10'h240);
        check("overrun_sticky", {15'b0, overrun}, 16'h1);

        // Wrap: delay 15 across the pointer wrap with a ramp.
        do_reset();
        check("overrun_cleared", {15'b0, overrun}, 16'h0);
        for (int n = 0; n < 40; n++) begin
            int e;
            e = 'h200 + 4 * n + ((n >= 15) ? 4 * (n - 15) : 0);
            do_tick(10'(10'h181 + 4 * n), 4'd15, 3'd0, 1'b0, 10'(e));
        end

        drain();
        repeat (4) @(negedge sysclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
